// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared types and helpers for the SpMV memory arbiter
package spmv_pkg;

  localparam int NTID     = 64;
  localparam int TID_W    = 6;
  localparam int TAG_W    = 6;
  localparam int NREQ_MAX = 8;

  typedef struct packed {
    logic [2:0]       req_id;
    logic [TAG_W-1:0] tag;
  } owner_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First asserted request at or after ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                    input logic [2:0]          ptr,
                                    input int                  nreq);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % nreq;
      if (k < nreq && req[3'(idx)]) begin
        p.found = 1'b1;
        p.idx   = 3'(idx);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/spmv_tid_pool.sv
// rtl/spmv_tid_pool.sv - global transid free pool with lowest-free allocation
module spmv_tid_pool
  import spmv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_en,
  output logic [TID_W-1:0] alloc_id,
  output logic             avail,
  input  logic             free_en,
  input  logic [TID_W-1:0] free_id,
  output logic [NTID-1:0]  busy,
  output logic [6:0]       outstanding
);

  always_comb begin
    alloc_id = '0;
    avail    = 1'b0;
    for (int i = NTID - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_id = TID_W'(i);
        avail    = 1'b1;
      end
    end
  end

  // The caller only frees ids that are busy, so alloc and free never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      if (alloc_en) busy[alloc_id] <= 1'b1;
      if (free_en)  busy[free_id]  <= 1'b0;
      case ({alloc_en, free_en})
        2'b10:   outstanding <= outstanding + 7'd1;
        2'b01:   outstanding <= outstanding - 7'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/spmv_mem_arb.sv
// rtl/spmv_mem_arb.sv - round-robin share of one NoC memory port among SpMV streamers
module spmv_mem_arb
  import spmv_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PADDR_W = 40,
  parameter int DATA_W  = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_val,
  output logic [NREQ-1:0]                req_rdy,
  input  logic [NREQ-1:0][PADDR_W-1:0]   req_addr,
  input  logic [NREQ-1:0][TAG_W-1:0]     req_tag,
  output logic                           mem_req_val,
  input  logic                           mem_req_rdy,
  output logic [TID_W-1:0]               mem_req_transid,
  output logic [PADDR_W-1:0]             mem_req_addr,
  input  logic                           mem_resp_val,
  input  logic [TID_W-1:0]               mem_resp_transid,
  input  logic [DATA_W-1:0]              mem_resp_data,
  output logic [NREQ-1:0]                resp_val,
  output logic [TAG_W-1:0]               resp_tag,
  output logic [DATA_W-1:0]              resp_data,
  output logic [6:0]                     outstanding,
  output logic                           err_spurious
);

  logic [2:0]          rr_ptr;
  pick_t               pick;
  logic                load;
  logic                pool_avail;
  logic [TID_W-1:0]    free_tid;
  logic [NTID-1:0]     busy;
  logic                resp_hit;
  logic [TAG_W-1:0]    sel_tag;
  logic [PADDR_W-1:0]  sel_addr;
  owner_t              owner_tab [NTID];
  owner_t              rd_owner;

  assign pick = rr_pick(NREQ_MAX'(req_val), rr_ptr, NREQ);
  assign load = rst_n && pick.found && pool_avail && (!mem_req_val || mem_req_rdy);
  assign req_rdy = load ? (NREQ'(1) << pick.idx) : '0;

  always_comb begin
    sel_tag  = '0;
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == pick.idx) begin
        sel_tag  = req_tag[i];
        sel_addr = req_addr[i];
      end
    end
  end

  assign resp_hit = mem_resp_val && busy[mem_resp_transid];
  assign rd_owner = owner_tab[mem_resp_transid];

  spmv_tid_pool u_pool (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_en    (load),
    .alloc_id    (free_tid),
    .avail       (pool_avail),
    .free_en     (resp_hit),
    .free_id     (mem_resp_transid),
    .busy        (busy),
    .outstanding (outstanding)
  );

  // Owner entries are only meaningful while their id is busy, so no reset.
  always_ff @(posedge clk) begin
    if (load) owner_tab[free_tid] <= '{req_id: pick.idx, tag: sel_tag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req_val     <= 1'b0;
      mem_req_transid <= '0;
      mem_req_addr    <= '0;
      rr_ptr          <= '0;
    end else if (load) begin
      mem_req_val     <= 1'b1;
      mem_req_transid <= free_tid;
      mem_req_addr    <= sel_addr;
      rr_ptr          <= (pick.idx == 3'(NREQ - 1)) ? 3'd0 : pick.idx + 3'd1;
    end else if (mem_req_rdy) begin
      mem_req_val     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_val     <= '0;
      resp_tag     <= '0;
      resp_data    <= '0;
      err_spurious <= 1'b0;
    end else begin
      resp_val     <= resp_hit ? (NREQ'(1) << rd_owner.req_id) : '0;
      err_spurious <= mem_resp_val && !busy[mem_resp_transid];
      if (resp_hit) begin
        resp_tag  <= rd_owner.tag;
        resp_data <= mem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_spmv_mem_arb.sv
// tb/tb_spmv_mem_arb.sv - self-checking bench for spmv_mem_arb
module tb_spmv_mem_arb;
  import spmv_pkg::*;

  localparam int NREQ    = 4;
  localparam int RW      = $clog2(NREQ);
  localparam int PADDR_W = 40;
  localparam int DATA_W  = 128;

  logic                         clk;
  logic                         rst_n;
  logic [NREQ-1:0]              req_val;
  logic [NREQ-1:0]              req_rdy;
  logic [NREQ-1:0][PADDR_W-1:0] req_addr;
  logic [NREQ-1:0][TAG_W-1:0]   req_tag;
  logic                         mem_req_val;
  logic                         mem_req_rdy;
  logic [TID_W-1:0]             mem_req_transid;
  logic [PADDR_W-1:0]           mem_req_addr;
  logic                         mem_resp_val;
  logic [TID_W-1:0]             mem_resp_transid;
  logic [DATA_W-1:0]            mem_resp_data;
  logic [NREQ-1:0]              resp_val;
  logic [TAG_W-1:0]             resp_tag;
  logic [DATA_W-1:0]            resp_data;
  logic [6:0]                   outstanding;
  logic                         err_spurious;

  spmv_mem_arb #(.NREQ(NREQ), .PADDR_W(PADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr), .req_tag(req_tag),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
    .mem_resp_data(mem_resp_data),
    .resp_val(resp_val), .resp_tag(resp_tag), .resp_data(resp_data),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: set of in-flight ids, owner per id, one pending NoC request.
  logic [NTID-1:0]    m_busy;
  int                 m_own_req [NTID];
  logic [TAG_W-1:0]   m_own_tag [NTID];
  int                 m_rr;
  bit                 m_or_val;
  int                 m_or_tid;
  logic [PADDR_W-1:0] m_or_addr;
  logic [NREQ-1:0]    m_resp_val;
  logic [TAG_W-1:0]   m_resp_tag;
  logic [DATA_W-1:0]  m_resp_data;
  bit                 m_err;
  int                 m_out;
  int                 issued [$];

  function automatic void model_pick(output int g, output int tid);
    int i;
    g = -1;
    tid = -1;
    if (!rst_n || (m_or_val && !mem_req_rdy)) return;
    for (int k = 0; k < NTID; k++) begin
      if (!m_busy[TID_W'(k)]) begin tid = k; break; end
    end
    if (tid < 0) return;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_rr + k) % NREQ;
      if (req_val[RW'(i)]) begin g = i; break; end
    end
    if (g < 0) tid = -1;
  endfunction

  task automatic tick();
    int g, tid, r;
    logic [NREQ-1:0] nrv;
    model_pick(g, tid);
    if (!rst_n) begin
      m_busy = '0; m_rr = 0; m_or_val = 0; m_or_tid = 0; m_or_addr = '0;
      m_resp_val = '0; m_resp_tag = '0; m_resp_data = '0; m_err = 0; m_out = 0;
      issued.delete();
    end else begin
      nrv = '0;
      m_err = 0;
      if (mem_resp_val) begin
        r = int'(mem_resp_transid);
        if (m_busy[TID_W'(r)]) begin
          nrv = NREQ'(1) << m_own_req[r];
          m_resp_tag = m_own_tag[r];
          m_resp_data = mem_resp_data;
          m_busy[TID_W'(r)] = 1'b0;
          m_out--;
        end else begin
          m_err = 1;
        end
      end
      m_resp_val = nrv;
      if (m_or_val && mem_req_rdy) issued.push_back(m_or_tid);
      if (g >= 0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == g) begin
            m_own_tag[tid] = req_tag[RW'(i)];
            m_or_addr = req_addr[RW'(i)];
          end
        end
        m_busy[TID_W'(tid)] = 1'b1;
        m_own_req[tid] = g;
        m_or_val = 1;
        m_or_tid = tid;
        m_rr = (g + 1) % NREQ;
        m_out++;
      end else if (mem_req_rdy) begin
        m_or_val = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req_val = '0; req_addr = '0; req_tag = '0;
    mem_req_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_transid = '0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_idle(); tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec += 5;
    if (mem_req_val !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_val: got %0h want 0", mem_req_val); end
    if (req_rdy !== '0) begin n_err++; $display("FAIL reset_req_rdy: got %0h want 0", req_rdy); end
    if (resp_val !== '0) begin n_err++; $display("FAIL reset_resp_val: got %0h want 0", resp_val); end
    if (outstanding !== 7'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    if (err_spurious !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0h want 0", err_spurious); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    req_val = 4'b0001; req_addr[0] = 40'h1000; req_tag[0] = 6'd5;
    #1;
    n_vec++;
    if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL single_rdy: got %0h want 1", req_rdy); end
    tick();
    req_val = '0;
    n_vec += 3;
    if (mem_req_val !== 1'b1) begin n_err++; $display("FAIL single_val: got %0h want 1", mem_req_val); end
    if (mem_req_transid !== 6'd0) begin n_err++; $display("FAIL single_tid: got %0d want 0", mem_req_transid); end
    if (mem_req_addr !== 40'h1000) begin n_err++; $display("FAIL single_addr: got %0h want 1000", mem_req_addr); end
    tick();
    mem_resp_val = 1'b1; mem_resp_transid = 6'd0; mem_resp_data = d;
    #1;
    n_vec++;
    if (resp_val !== '0) begin n_err++; $display("FAIL single_resp_early: got %0h want 0", resp_val); end
    tick();
    mem_resp_val = 1'b0;
    n_vec += 4;
    if (resp_val !== 4'b0001) begin n_err++; $display("FAIL single_resp_val: got %0h want 1", resp_val); end
    if (resp_tag !== 6'd5) begin n_err++; $display("FAIL single_resp_tag: got %0d want 5", resp_tag); end
    if (resp_data !== d) begin n_err++; $display("FAIL single_resp_data: got %0h want %0h", resp_data, d); end
    if (outstanding !== 7'd0) begin n_err++; $display("FAIL single_outstanding: got %0d want 0", outstanding); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_val = '1;
      for (int j = 0; j < NREQ; j++) begin
        req_tag[RW'(j)] = TAG_W'(i);
        req_addr[RW'(j)] = PADDR_W'(i * 64 + j);
      end
      #1;
      exp = NREQ'(1) << (i % NREQ);
      n_vec++;
      if (req_rdy !== exp) begin n_err++; $display("FAIL rr_grant%0d: got %0h want %0h", i, req_rdy, exp); end
      tick();
      n_vec++;
      if (mem_req_val !== 1'b1 || mem_req_transid !== TID_W'(i)) begin
        n_err++; $display("FAIL rr_tid%0d: got %0d want %0d", i, mem_req_transid, i);
      end
    end
    req_val = '0;
    tick();
    n_vec++;
    if (outstanding !== 7'd8) begin n_err++; $display("FAIL rr_outstanding: got %0d want 8", outstanding); end
  endtask

  task automatic test_pool_full();
    req_val = '1;
    for (int i = 8; i < NTID; i++) tick();
    #1;
    n_vec++;
    if (req_rdy !== '0) begin n_err++; $display("FAIL full_rdy: got %0h want 0", req_rdy); end
    tick();
    n_vec++;
    if (outstanding !== 7'd64) begin n_err++; $display("FAIL full_outstanding: got %0d want 64", outstanding); end
    mem_resp_val = 1'b1; mem_resp_transid = 6'd17; mem_resp_data = '1;
    tick();
    mem_resp_val = 1'b0;
    #1;
    n_vec += 2;
    if (resp_val !== 4'b0010) begin n_err++; $display("FAIL full_resp17: got %0h want 2", resp_val); end
    if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL full_regrant: got %0h want 1", req_rdy); end
    tick();
    n_vec++;
    if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd17) begin
      n_err++; $display("FAIL full_reissue17: got %0d want 17", mem_req_transid);
    end
    req_val = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    mem_req_rdy = 1'b0;
    req_val = 4'b0001; req_addr[0] = 40'h2000; req_tag[0] = 6'd9;
    #1;
    n_vec++;
    if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL stall_first: got %0h want 1", req_rdy); end
    tick();
    req_addr[0] = 40'h2040;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec += 4;
      if (req_rdy !== '0) begin n_err++; $display("FAIL stall_rdy%0d: got %0h want 0", i, req_rdy); end
      if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd0) begin
        n_err++; $display("FAIL stall_tid%0d: got %0d want 0", i, mem_req_transid);
      end
      if (mem_req_addr !== 40'h2000) begin n_err++; $display("FAIL stall_addr%0d: got %0h want 2000", i, mem_req_addr); end
      if (outstanding !== 7'd1) begin n_err++; $display("FAIL stall_out%0d: got %0d want 1", i, outstanding); end
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    n_vec++;
    if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL stall_release: got %0h want 1", req_rdy); end
    tick();
    req_val = '0;
    n_vec++;
    if (mem_req_transid !== 6'd1 || mem_req_addr !== 40'h2040) begin
      n_err++; $display("FAIL stall_next: got %0d/%0h want 1/2040", mem_req_transid, mem_req_addr);
    end
    tick();
  endtask

  task automatic test_spurious();
    mem_resp_val = 1'b1; mem_resp_transid = 6'd40;
    tick();
    mem_resp_val = 1'b0;
    n_vec += 3;
    if (err_spurious !== 1'b1) begin n_err++; $display("FAIL spur_pulse: got %0h want 1", err_spurious); end
    if (resp_val !== '0) begin n_err++; $display("FAIL spur_resp_val: got %0h want 0", resp_val); end
    if (outstanding !== 7'd2) begin n_err++; $display("FAIL spur_outstanding: got %0d want 2", outstanding); end
    tick();
    n_vec++;
    if (err_spurious !== 1'b0) begin n_err++; $display("FAIL spur_width: got %0h want 0", err_spurious); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_val = '1;
    for (int i = 0; i < 10; i++) tick();
    req_val = '0;
    tick();
    n_vec++;
    if (outstanding !== 7'd10) begin n_err++; $display("FAIL midop_pre: got %0d want 10", outstanding); end
    rst_n = 1'b0;
    req_val = '1;
    tick();
    req_val = '0;
    rst_n = 1'b1;
    n_vec += 2;
    if (outstanding !== 7'd0) begin n_err++; $display("FAIL midop_outstanding: got %0d want 0", outstanding); end
    if (mem_req_val !== 1'b0) begin n_err++; $display("FAIL midop_mem_req_val: got %0h want 0", mem_req_val); end
    mem_resp_val = 1'b1; mem_resp_transid = 6'd3;
    tick();
    mem_resp_val = 1'b0;
    n_vec += 2;
    if (err_spurious !== 1'b1) begin n_err++; $display("FAIL midop_late_resp: got %0h want 1", err_spurious); end
    if (resp_val !== '0) begin n_err++; $display("FAIL midop_resp_val: got %0h want 0", resp_val); end
    tick();
  endtask

  task automatic test_random();
    bit pend [NREQ];
    int g, tid, k, r;
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_vec += 4;
      if (mem_req_val !== m_or_val) begin n_err++; $display("FAIL rnd_mem_req_val@%0d: got %0h want %0h", cyc, mem_req_val, m_or_val); end
      else if (m_or_val && (mem_req_transid !== TID_W'(m_or_tid) || mem_req_addr !== m_or_addr)) begin
        n_err++; $display("FAIL rnd_mem_req@%0d: got %0d/%0h want %0d/%0h", cyc, mem_req_transid, mem_req_addr, m_or_tid, m_or_addr);
      end
      if (resp_val !== m_resp_val || (|m_resp_val && (resp_tag !== m_resp_tag || resp_data !== m_resp_data))) begin
        n_err++; $display("FAIL rnd_resp@%0d: got %0h/%0h want %0h/%0h", cyc, resp_val, resp_tag, m_resp_val, m_resp_tag);
      end
      if (outstanding !== 7'(m_out)) begin n_err++; $display("FAIL rnd_outstanding@%0d: got %0d want %0d", cyc, outstanding, m_out); end
      if (err_spurious !== m_err) begin n_err++; $display("FAIL rnd_err@%0d: got %0h want %0h", cyc, err_spurious, m_err); end

      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          req_addr[RW'(i)] = PADDR_W'({$urandom, $urandom});
          req_tag[RW'(i)] = TAG_W'($urandom);
        end
        req_val[RW'(i)] = pend[i];
      end
      mem_req_rdy = ($urandom_range(0, 3) != 0);
      mem_resp_val = 1'b0;
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      if (issued.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, issued.size() - 1);
        mem_resp_val = 1'b1;
        mem_resp_transid = TID_W'(issued[k]);
        issued.delete(k);
      end else if ($urandom_range(0, 14) == 0) begin
        r = $urandom_range(0, NTID - 1);
        if (!m_busy[TID_W'(r)]) begin
          mem_resp_val = 1'b1;
          mem_resp_transid = TID_W'(r);
        end
      end
      #1;
      model_pick(g, tid);
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      n_vec++;
      if (req_rdy !== exp_rdy) begin n_err++; $display("FAIL rnd_req_rdy@%0d: got %0h want %0h", cyc, req_rdy, exp_rdy); end
      tick();
      if (g >= 0) pend[g] = 0;
      if (!rst_n) for (int i = 0; i < NREQ; i++) pend[i] = 0;
    end
    rst_n = 1'b1;
    set_idle();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_pool_full();
    test_stall();
    test_spurious();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
